// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcode encoding and the buffered command record.
package alu_pkg;

    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [31:0]      a;
        logic [3:0]       b;
        alu_op_e          sel;
        logic [TAG_W-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command and response handshakes of the ALU issue stage.
interface alu_issue_stage_if #(
    parameter int TAG_W = alu_pkg::TAG_W
) ();
    import alu_pkg::alu_op_e;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [3:0]       cmd_b;
    alu_op_e          cmd_sel;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    alu_op_e          rsp_sel;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_tag, rsp_sel,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_tag, rsp_sel,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of command records; the head is read straight from registered storage
// and forced to zero when empty.
module alu_cmd_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = alu_pkg::alu_cmd_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign level   = level_q;
    assign head    = empty ? entry_t'('0) : mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: queues commands, presents the head to the combinational ALU and captures
// its result into a valid/ready response slot, counting issues per opcode.
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = alu_pkg::TAG_W,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_stage_if.slave       bus,
    output logic [31:0]            alu_a,
    output logic [3:0]             alu_b,
    output logic [1:0]             alu_sel,
    input  logic [31:0]            alu_result,
    output logic [4*CNT_W-1:0]     op_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    import alu_pkg::alu_op_e;
    import alu_pkg::ALU_ADD;

    typedef struct packed {
        logic [31:0]      a;
        logic [3:0]       b;
        alu_op_e          sel;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    cmd_t push_data;
    cmd_t head;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic cap;

    logic             rsp_valid_q,  rsp_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;
    alu_op_e          rsp_sel_q,    rsp_sel_d;

    assign push_data.a   = bus.cmd_a;
    assign push_data.b   = bus.cmd_b;
    assign push_data.sel = bus.cmd_sel;
    assign push_data.tag = bus.cmd_tag;

    assign bus.cmd_ready = !fifo_full;
    assign push          = bus.cmd_valid && !fifo_full;
    // Capture from registered FIFO state only, so a fresh push never bypasses into this cycle.
    assign cap           = !fifo_empty && (!rsp_valid_q || bus.rsp_ready);

    alu_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cmd_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (cap),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign alu_a   = head.a;
    assign alu_b   = head.b;
    assign alu_sel = head.sel;

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_sel_d    = rsp_sel_q;
        if (cap) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_tag_d    = head.tag;
            rsp_sel_d    = head.sel;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_sel_q    <= ALU_ADD;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_sel_q    <= rsp_sel_d;
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_sel    = rsp_sel_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             hit;

        assign hit   = cap && (head.sel == 2'(gi));
        // Saturate at all-ones rather than wrapping.
        assign cnt_d = (hit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

        always_ff @(posedge clk) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end

        assign op_count[gi*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed commands push expected responses,
// a negedge monitor pops and compares every accepted response.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_a, alu_a2;
    logic [3:0]  alu_b, alu_b2;
    logic [1:0]  alu_sel, alu_sel2;
    logic [31:0] alu_result, alu_result2;
    logic [63:0] op_count;
    logic [7:0]  op_count2;
    logic [2:0]  fifo_level, fifo_level2;

    int checks = 0;
    int fails  = 0;
    int rsp_seen = 0;
    bit lvl_watch = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.TAG_W(4)) bus ();
    alu_issue_stage_if #(.TAG_W(4)) bus2 ();

    alu_issue_stage #(.DEPTH(4), .TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .op_count(op_count), .fifo_level(fifo_level)
    );

    alu_issue_stage #(.DEPTH(4), .TAG_W(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2), .alu_result(alu_result2),
        .op_count(op_count2), .fifo_level(fifo_level2)
    );

    // The combinational ALU that the stage feeds.
    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [3:0] b, logic [1:0] s);
        case (s)
            2'd0:    return a + {28'd0, b};
            2'd1:    return a - {28'd0, b};
            2'd2:    return a & {28'd0, b};
            default: return a | {28'd0, b};
        endcase
    endfunction

    assign alu_result  = alu_fn(alu_a, alu_b, alu_sel);
    assign alu_result2 = alu_fn(alu_a2, alu_b2, alu_sel2);

    // Directed vectors; opcode is index mod 4, tag is the index, results hand-computed.
    logic [31:0] va [16] = '{32'h0000_0001, 32'h0000_0010, 32'hFFFF_00F5, 32'h1234_5670,
                             32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_000F, 32'h8000_0000,
                             32'h0000_00FF, 32'h1000_0000, 32'hAAAA_AAAA, 32'h0000_0000,
                             32'h7FFF_FFFF, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_00F0};
    logic [3:0]  vb [16] = '{4'h1, 4'h3, 4'hC, 4'h9, 4'h1, 4'h1, 4'hA, 4'h0,
                             4'hF, 4'hF, 4'h7, 4'h5, 4'h1, 4'h5, 4'hF, 4'hF};
    logic [31:0] vr [16] = '{32'h0000_0002, 32'h0000_000D, 32'h0000_0004, 32'h1234_5679,
                             32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000A, 32'h8000_0000,
                             32'h0000_010E, 32'h0FFF_FFF1, 32'h0000_0002, 32'h0000_0005,
                             32'h8000_0000, 32'h0000_0000, 32'h0000_000F, 32'h0000_00FF};

    typedef struct {
        logic [31:0] result;
        logic [3:0]  tag;
        alu_op_e     sel;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [3:0] b, input alu_op_e sel,
                        input logic [3:0] tag, input logic [31:0] exp);
        int waited = 0;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_sel = sel; bus.cmd_tag = tag;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (lvl_watch) chk("wrap_level", 64'(fifo_level), 64'd2);
        if (!bus.cmd_ready) begin
            checks++; fails++;
            $display("FAIL send_timeout tag=%0d actual=cmd_ready_low required=accepted", tag);
        end else begin
            sb.push_back('{exp, tag, sel});
            $display("cmd  tag=%0d sel=%0d a=%08h b=%0h", tag, sel, a, b);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_vec(input int i);
        send(va[i], vb[i], alu_op_e'(i % 4), 4'(i), vr[i]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every response accepted by the consumer is compared with the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            rsp_seen++;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_rsp actual=tag%0d result=%08h required=none",
                         bus.rsp_tag, bus.rsp_result);
            end else begin
                e = sb.pop_front();
                if ({bus.rsp_result, bus.rsp_tag, bus.rsp_sel} !== {e.result, e.tag, e.sel}) begin
                    fails++;
                    $display("FAIL rsp actual=%08h/tag%0d/sel%0d required=%08h/tag%0d/sel%0d",
                             bus.rsp_result, bus.rsp_tag, bus.rsp_sel, e.result, e.tag, e.sel);
                end else begin
                    $display("rsp  tag=%0d sel=%0d result=%08h", e.tag, e.sel, e.result);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_sel = ALU_ADD; bus.cmd_tag = 0;
        bus.rsp_ready = 0;
        bus2.cmd_valid = 0; bus2.cmd_a = 0; bus2.cmd_b = 0; bus2.cmd_sel = ALU_ADD; bus2.cmd_tag = 0;
        bus2.rsp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", {28'd0, bus.rsp_result, bus.rsp_tag}, 64'd0);
        chk("rst_rsp_sel", 64'(bus.rsp_sel), 64'd0);
        chk("rst_alu_drive", {26'd0, alu_a, alu_b, alu_sel}, 64'd0);
        chk("rst_op_count", op_count, 64'd0);
        rst_n = 1'b1;

        // Single ADD: response appears exactly one edge after acceptance.
        @(posedge clk); #1;
        bus.rsp_ready = 1;
        send(32'h0000_0010, 4'h3, ALU_ADD, 4'd5, 32'h0000_0013);
        @(negedge clk);
        chk("single_rsp_not_yet", 64'(bus.rsp_valid), 64'd0);
        chk("single_level", 64'(fifo_level), 64'd1);
        @(negedge clk);
        chk("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_add_count", 64'(op_count[15:0]), 64'd1);
        @(posedge clk); #1;

        // Back-pressure: slot holds the first, FIFO fills with the other four.
        bus.rsp_ready = 0;
        for (int i = 0; i < 5; i++) send_vec(i);
        @(negedge clk);
        chk("bp_level", 64'(fifo_level), 64'd4);
        chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("bp_slot_tag", {59'd0, bus.rsp_valid, bus.rsp_tag}, {59'd0, 1'b1, 4'd0});
        bus.cmd_a = 32'h5555_5555; bus.cmd_tag = 4'd9; bus.cmd_valid = 1;
        @(posedge clk); #1;
        bus.cmd_valid = 0;
        @(negedge clk);
        chk("bp_full_hold", 64'(fifo_level), 64'd4);
        @(posedge clk); #1;
        bus.rsp_ready = 1;
        wait_drain();

        // Reset mid-stream with one response pending and three entries queued.
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        for (int i = 5; i < 9; i++) send_vec(i);
        @(negedge clk);
        chk("mid_level_before", 64'(fifo_level), 64'd3);
        @(posedge clk); #1;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_op_count", op_count, 64'd0);
        chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        sb.delete();
        rst_n = 1;
        @(posedge clk); #1;
        bus.rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_stale", 64'(bus.rsp_valid), 64'd0);
        end

        // Streaming: 16 back-to-back commands, one response per cycle.
        @(posedge clk); #1;
        base = rsp_seen;
        for (int i = 0; i < 16; i++) send_vec(i);
        repeat (3) @(negedge clk);
        chk("stream_rsp_count", 64'(rsp_seen - base), 64'd16);
        chk("stream_op_count", op_count, {16'd4, 16'd4, 16'd4, 16'd4});

        // Level held at 2 under simultaneous push/pop, wrapping the pointers several times.
        @(posedge clk); #1;
        bus.rsp_ready = 0;
        for (int i = 0; i < 3; i++) send_vec(i);
        @(negedge clk);
        chk("wrap_level_start", 64'(fifo_level), 64'd2);
        @(posedge clk); #1;
        bus.rsp_ready = 1;
        lvl_watch = 1;
        for (int k = 3; k < 15; k++) send_vec(k);
        lvl_watch = 0;
        wait_drain();

        // Saturation on the 2-bit counter instance: five SUBs stop at 3.
        @(posedge clk); #1;
        bus2.cmd_a = 32'h0000_0100; bus2.cmd_b = 4'h1; bus2.cmd_sel = ALU_SUB; bus2.cmd_valid = 1;
        for (int i = 0; i < 5; i++) begin
            bus2.cmd_tag = 4'(i);
            @(negedge clk);
            chk("sat_cmd_ready", 64'(bus2.cmd_ready), 64'd1);
            @(posedge clk); #1;
        end
        bus2.cmd_valid = 0;
        repeat (4) @(negedge clk);
        chk("sat_op_count", 64'(op_count2), 64'h0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Upstream issue/capture stage for the combinational ALU. It buffers incoming operation commands in a small FIFO and drives the FIFO head onto the ALU operand/select inputs. One cycle later it registers the ALU RESULT, together with the command's tag and opcode, into a response slot with a valid/ready handshake. This decouples the command producer and result consumer from the ALU's combinational path and keeps per-opcode issue statistics.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, minimum 2
TAG_W, 4, width of the opaque command tag returned with each result
CNT_W, 16, width of each per-opcode saturating issue counter

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; high when count < DEPTH
cmd_a  in  32  operand A
cmd_b  in  4  operand B
cmd_sel  in  2  opcode (alu_pkg::alu_op_e)
cmd_tag  in  TAG_W  opaque tag
alu_a  out  32  to ALU A (FIFO head)
alu_b  out  4  to ALU B (FIFO head)
alu_sel  out  2  to ALU SEL (FIFO head)
alu_result  in  32  from ALU RESULT (combinational function of alu_a/b/sel)
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  captured ALU result
rsp_tag  out  TAG_W  tag of the captured command
rsp_sel  out  2  opcode of the captured command
op_count  out  4*CNT_W  packed issue counters, index = opcode (ADD in [CNT_W-1:0])
fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low at a clock edge): FIFO empty, fifo_level=0, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_sel=0, alu_a/b/sel=0, all op_count fields=0. Reset mid-operation discards FIFO contents and any pending response without emitting them.
- Push: cmd_valid && cmd_ready at an edge writes {a,b,sel,tag} at the tail.
- ALU drive: when the FIFO is non-empty, alu_a/b/sel are the head entry (registered storage, no combinational path from cmd_*). When empty, they are 0.
- Capture condition: cap = fifo_nonempty && (!rsp_valid || rsp_ready). At the edge with cap: rsp_result<=alu_result, rsp_tag<=head tag, rsp_sel<=head sel, rsp_valid<=1, head popped, op_count[head sel] += 1, saturating at all-ones.
- Drain: rsp_valid && rsp_ready && !cap -> rsp_valid<=0. rsp_* data holds while rsp_valid && !rsp_ready.
- Latency: a command accepted at edge N into an empty stage with rsp_ready=1 has rsp_valid=1 from edge N+1 (visible in cycle N+1..N+2). Throughput is 1 op/cycle when rsp_ready stays high.
- Simultaneous push and pop: fifo_level unchanged. A push into a full FIFO is impossible because cmd_ready=0. Push when empty: head is valid the next cycle, with no bypass into the same-cycle capture.
- Pointers wrap modulo DEPTH. fifo_level ranges 0..DEPTH.
- Ordering: responses are strictly in command order.
- No arithmetic is performed here. Result width and semantics are the ALU's.

Decomposition:
- alu_pkg: typedef enum logic [1:0] alu_op_e {ALU_ADD=2'd0, ALU_SUB=2'd1, ALU_AND=2'd2, ALU_OR=2'd3}, plus typedef struct packed alu_cmd_t {a[31:0], b[3:0], sel, tag}. TAG_W is a package localparam default shared with consumers.
- One sub-module: alu_cmd_fifo (parameterised sync FIFO of alu_cmd_t, with push/pop/full/empty/level). The capture/response slot and counters stay in alu_issue_stage.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles mid-stream with 3 entries queued -> fifo_level=0, rsp_valid=0, op_count=0, cmd_ready=1, and no stale response after release.
- Single op: push a=32'h0000_0010, b=4'h3, sel=ADD, tag=5 with the ALU model connected -> rsp_valid high one cycle after acceptance, rsp_result=32'h13, rsp_tag=5, op_count[ADD]=1.
- Back-pressure: rsp_ready=0, push 5 commands (DEPTH=4) -> first captured into rsp slot, fifo_level=4, cmd_ready=0 on the fifth. Release rsp_ready -> 5 responses in order with tags 0..4.
- Streaming: rsp_ready=1, push one command per cycle for 16 cycles cycling sel 0..3 -> one response per cycle, in order, each op_count field=4.
- Simultaneous push/pop at level 2 -> level stays 2, and the tail wraps correctly across 3 full wraps (12+ entries) with no data corruption.
- Saturation: CNT_W=2, issue 5 SUBs -> op_count[SUB]=3, other fields 0.
